// File: rtl/mem_lsu.sv
// MEM-stage load/store unit.
// Takes the EX-stage data-memory request and runs it on the data bus using a
// valid/ready request phase followed by a response phase. Load data is
// aligned and extended for write-back. The unit stalls the pipeline while a
// bus transaction is in flight. Misalignment, bus errors and timeouts are
// reported as one-cycle exception pulses.
module mem_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            mem_re_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [4:0]      mem_l_mask_i,
    input  logic [3:0]      mem_byte_we_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    output logic            dbus_req_valid,
    input  logic            dbus_req_ready,
    output logic [XLEN-1:0] dbus_addr,
    output logic            dbus_we,
    output logic [3:0]      dbus_wstrb,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_rsp_valid,
    input  logic [XLEN-1:0] dbus_rdata,
    input  logic            dbus_rsp_err,
    output logic            lsu_busy,
    output logic            lsu_done,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_exp_flag,
    output logic [1:0]      lsu_exp_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Load-kind one-hot bit positions.
    localparam int K_LB  = 0;
    localparam int K_LH  = 1;
    localparam int K_LW  = 2;
    localparam int K_LBU = 3;
    localparam int K_LHU = 4;

    localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_BUSERR   = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // Select the addressed byte/half from the bus word and extend it.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [4:0]      kind,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [XLEN-1:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        if (kind[K_LB]) begin
            res = {{(XLEN-8){b[7]}}, b};
        end else if (kind[K_LBU]) begin
            res = {{(XLEN-8){1'b0}}, b};
        end else if (kind[K_LH]) begin
            res = {{(XLEN-16){h[15]}}, h};
        end else if (kind[K_LHU]) begin
            res = {{(XLEN-16){1'b0}}, h};
        end else begin
            res = word;
        end
        return res;
    endfunction

    // Halfword loads need addr[0]=0, word loads need addr[1:0]=0.
    function automatic logic load_misaligned(
        input logic [4:0] kind,
        input logic [1:0] off
    );
        logic res;
        res = ((kind[K_LH] | kind[K_LHU]) & off[0]) |
              (kind[K_LW] & (off != 2'b00));
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [4:0]      kind_q, kind_d;
    logic            we_q, we_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            exp_flag_q, exp_flag_d;
    logic [1:0]      exp_cause_q, exp_cause_d;
    logic            req_valid_q, req_valid_d;
    logic            done_q, done_d;
    logic            new_acc_s;
    logic            busy_s;

    assign new_acc_s = (mem_re_i | mem_we_i) & ~pipe_flush;

    // Next-state and datapath logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        kind_d      = kind_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        rdata_d     = rdata_q;
        exp_flag_d  = 1'b0;
        exp_cause_d = exp_cause_q;
        busy_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (new_acc_s) begin
                    busy_s = 1'b1;
                    if (mem_re_i && load_misaligned(mem_l_mask_i, mem_addr_i[1:0])) begin
                        // No bus activity: fault reported next cycle.
                        exp_flag_d  = 1'b1;
                        exp_cause_d = CAUSE_MISALIGN;
                    end else begin
                        addr_d  = mem_addr_i;
                        kind_d  = mem_re_i ? mem_l_mask_i : 5'b00000;
                        we_d    = mem_we_i;
                        wstrb_d = mem_we_i ? mem_byte_we_i : 4'b0000;
                        wdata_d = mem_wdata_i << {mem_addr_i[1:0], 3'b000};
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            S_REQ: begin
                busy_s = 1'b1;
                if (pipe_flush) begin
                    state_d = S_IDLE;
                end else if (dbus_req_ready) begin
                    cnt_d   = 8'd0;
                    kill_d  = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                busy_s = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (dbus_rsp_valid) begin
                    // Response always consumed; a flush only hides its result.
                    state_d = S_IDLE;
                    if (pipe_flush || kill_q) begin
                        kill_d = 1'b0;
                    end else if (dbus_rsp_err) begin
                        exp_flag_d  = 1'b1;
                        exp_cause_d = CAUSE_BUSERR;
                    end else begin
                        if (!we_q) begin
                            rdata_d = load_extract(kind_q, addr_q[1:0], dbus_rdata);
                        end else begin
                            rdata_d = rdata_q;
                        end
                        state_d = S_DONE;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_IDLE;
                    if (pipe_flush || kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        exp_flag_d  = 1'b1;
                        exp_cause_d = CAUSE_TIMEOUT;
                    end
                end else if (pipe_flush) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            S_DONE: begin
                // Requests seen here are picked up in the following IDLE cycle.
                busy_s  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        req_valid_d = (state_d == S_REQ);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            kind_q      <= 5'b00000;
            we_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= '0;
            cnt_q       <= 8'd0;
            kill_q      <= 1'b0;
            rdata_q     <= '0;
            exp_flag_q  <= 1'b0;
            exp_cause_q <= 2'd0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            kind_q      <= kind_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            rdata_q     <= rdata_d;
            exp_flag_q  <= exp_flag_d;
            exp_cause_q <= exp_cause_d;
            req_valid_q <= req_valid_d;
            done_q      <= done_d;
        end
    end

    assign dbus_req_valid = req_valid_q;
    assign dbus_addr      = {addr_q[XLEN-1:2], 2'b00};
    assign dbus_we        = we_q;
    assign dbus_wstrb     = wstrb_q;
    assign dbus_wdata     = wdata_q;
    assign lsu_busy       = busy_s | (state_q == S_REQ) | (state_q == S_WAIT);
    assign lsu_done       = done_q;
    assign lsu_rdata      = rdata_q;
    assign lsu_exp_flag   = exp_flag_q;
    assign lsu_exp_cause  = exp_cause_q;

endmodule
